// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX path: the arbiter state type, the
// round-robin pick function, and the default word/timing constants that the
// serializer and its bench also use.
package uart_pkg;

  // Defaults shared with the serializer (50 MHz clock, 115200 baud).
  localparam int CLOCKS_PER_PULSE = 434;
  localparam int BITS_PER_WORD    = 8;
  localparam int W_OUT            = 16;

  // Widest requester vector the pick function handles.
  localparam int MAX_REQ  = 16;
  localparam int MAX_ID_W = 4;

  typedef enum logic {IDLE, SEND} arb_state_t;

  // Return a one-hot grant for the first set bit of req, starting at index ptr
  // and wrapping modulo n. Bits at or above n are ignored.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0]  req,
    input logic [MAX_ID_W-1:0] ptr,
    input int                  n
  );
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    int                 idx;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      // ptr < n and i < n, so one subtraction is enough to wrap.
      idx = int'(ptr) + i;
      if (idx >= n) idx = idx - n;
      if ((i < n) && !found && req[idx[MAX_ID_W-1:0]]) begin
        gnt[idx[MAX_ID_W-1:0]] = 1'b1;
        found                  = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: one-hot grant, its index, and an
// any-grant flag, searching from ptr upward with wrap at NUM_REQ.
module rr_grant
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any
);

  assign gnt = NUM_REQ'(rr_pick(MAX_REQ'(req), MAX_ID_W'(ptr), NUM_REQ));
  assign any = |gnt;

  // Encode the one-hot grant into an index.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    gnt_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_id = ID_W'(i);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one AXI-Stream UART TX serializer between
// NUM_REQ word sources. A granted word sits in a single-entry holding
// register until the serializer takes it; only then does the grant rotate.
// Build option: define UART_ARB_PRIO0_EN to make requester 0 strict high
// priority, with requesters 1..NUM_REQ-1 rotating among themselves.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int W_OUT   = uart_pkg::W_OUT,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            s_valid,
  output logic [NUM_REQ-1:0]            s_ready,
  input  logic [NUM_REQ-1:0][W_OUT-1:0] s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [W_OUT-1:0]              m_data,
  output logic [ID_W-1:0]               m_id,
  output logic                          busy
);

  arb_state_t         state;
  arb_state_t         state_next;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    ptr_next;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_any;
  logic               take;
  logic               accept;

  // A word is captured from the granted source in IDLE and released to the
  // serializer on the valid/ready handshake in SEND.
  assign take   = (state == IDLE) && gnt_any;
  assign accept = (state == SEND) && m_ready;

  // Pointer moves one past the owner of the word just sent, wrapping at
  // NUM_REQ-1 even when NUM_REQ is not a power of two.
  assign ptr_next = (m_id == ID_W'(NUM_REQ - 1)) ? '0 : m_id + ID_W'(1);

`ifdef UART_ARB_PRIO0_EN
  logic [NUM_REQ-1:0] rr_gnt;
  logic [ID_W-1:0]    rr_id;
  logic               rr_any;

  // Requester 0 is removed from the rotation; the others share it.
  rr_grant #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_grant (
    .req    ({s_valid[NUM_REQ-1:1], 1'b0}),
    .ptr    (rr_ptr),
    .gnt    (rr_gnt),
    .gnt_id (rr_id),
    .any    (rr_any)
  );

  // Requester 0 overrides the rotating pick whenever it is valid.
  always_comb begin
    gnt    = rr_gnt;
    gnt_id = rr_id;
    if (s_valid[0]) begin
      gnt    = NUM_REQ'(1);
      gnt_id = '0;
    end
  end

  assign gnt_any = s_valid[0] | rr_any;
`else
  rr_grant #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_grant (
    .req    (s_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (gnt_any)
  );
`endif

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: leave IDLE on a grant, leave SEND on serializer acceptance.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (gnt_any) state_next = SEND;
      SEND: if (m_ready) state_next = IDLE;
    endcase
  end

  // Outputs: grant is offered only in IDLE and is forced off during reset so
  // no source sees a handshake the arbiter cannot take.
  always_comb begin
    s_ready = '0;
    if ((state == IDLE) && rstn) s_ready = gnt;
    m_valid = (state == SEND);
    busy    = (state == SEND);
  end

  // Holding register: capture the granted word and its owner.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: the holding register is reset so m_data and m_id read zero out of
    // reset; wide datapath registers are otherwise commonly left unreset.
    if (!rstn) begin
      m_data <= '0;
      m_id   <= '0;
    end else if (take) begin
      m_data <= s_data[gnt_id];
      m_id   <= gnt_id;
    end
  end

  // Round-robin pointer advances only once the serializer has the word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr <= '0;
    end else if (accept) begin
`ifdef UART_ARB_PRIO0_EN
      if (m_id != '0) rr_ptr <= ptr_next;
`else
      rr_ptr <= ptr_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with NUM_REQ=4, W_OUT=16. Expected grant
// orders are written out by hand for both builds of UART_ARB_PRIO0_EN.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int W       = 16;
  localparam int ID_W    = 2;

  logic                      clk;
  logic                      rstn;
  logic [NUM_REQ-1:0]        s_valid;
  logic [NUM_REQ-1:0]        s_ready;
  logic [NUM_REQ-1:0][W-1:0] s_data;
  logic                      m_valid;
  logic                      m_ready;
  logic [W-1:0]              m_data;
  logic [ID_W-1:0]           m_id;
  logic                      busy;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  int exp_e[6];
  int exp_g[5];
  int exp_f;

  uart_tx_arbiter #(
    .NUM_REQ (NUM_REQ),
    .W_OUT   (W)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_id    (m_id),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef UART_ARB_PRIO0_EN
    exp_e = '{0, 0, 0, 0, 0, 0};
    exp_f = 0;
    exp_g = '{0, 0, 0, 2, 2};
`else
    exp_e = '{0, 1, 2, 3, 0, 1};
    exp_f = 2;
    exp_g = '{2, 0, 2, 2, 2};
`endif
    rstn    = 1'b0;
    s_valid = '0;
    m_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) s_data[i] = 16'(16'h1000 + i);

    // Reset state.
    #2;
    chk("rst_m_valid", 32'(m_valid), 32'h0);
    chk("rst_busy",    32'(busy),    32'h0);
    chk("rst_s_ready", 32'(s_ready), 32'h0);
    chk("rst_m_data",  32'(m_data),  32'h0);
    chk("rst_m_id",    32'(m_id),    32'h0);
    tick();
    tick();
    rstn = 1'b1;

    // Single requester 2.
    s_valid   = 4'b0100;
    s_data[2] = 16'hA55A;
    m_ready   = 1'b1;
    #1;
    chk("single_s_ready", 32'(s_ready), 32'h4);
    tick();
    s_valid = '0;
    chk("single_m_valid", 32'(m_valid), 32'h1);
    chk("single_m_data",  32'(m_data),  32'hA55A);
    chk("single_m_id",    32'(m_id),    32'h2);
    chk("single_busy",    32'(busy),    32'h1);
    chk("single_s_ready_send", 32'(s_ready), 32'h0);
    tick();
    chk("single_done_m_valid", 32'(m_valid), 32'h0);
    chk("single_done_busy",    32'(busy),    32'h0);
    s_data[2] = 16'h1002;

    // m_ready high in IDLE with nothing requested: nothing happens.
    tick();
    chk("idle_ready_m_valid", 32'(m_valid), 32'h0);
    chk("idle_ready_s_ready", 32'(s_ready), 32'h0);

    // Wrap: rr_ptr=3 with requesters 1 and 3 -> 3 then 1.
    s_valid = 4'b1010;
    #1;
    chk("wrap_first_s_ready", 32'(s_ready), 32'h8);
    tick();
    chk("wrap_first_m_id",   32'(m_id),   32'h3);
    chk("wrap_first_m_data", 32'(m_data), 32'h1003);
    tick();
    chk("wrap_second_s_ready", 32'(s_ready), 32'h2);
    tick();
    chk("wrap_second_m_id",   32'(m_id),   32'h1);
    chk("wrap_second_m_data", 32'(m_data), 32'h1001);
    tick();
    // rr_ptr should now be 2: with 1,2,3 valid the pick is 2.
    s_valid = 4'b1110;
    #1;
    chk("wrap_ptr2_s_ready", 32'(s_ready), 32'h4);
    tick();
    chk("wrap_ptr2_m_id", 32'(m_id), 32'h2);
    tick();

    // Backpressure on a word from requester 3.
    s_valid = 4'b1000;
    m_ready = 1'b0;
    tick();
    chk("bp_start_m_id", 32'(m_id), 32'h3);
    s_valid = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      s_data[3] = 16'(16'hBE00 + i);
      tick();
      chk("bp_m_valid", 32'(m_valid), 32'h1);
      chk("bp_m_data",  32'(m_data),  32'h1003);
      chk("bp_s_ready", 32'(s_ready), 32'h0);
      chk("bp_busy",    32'(busy),    32'h1);
    end
    s_data[3] = 16'h1003;
    m_ready   = 1'b1;
    s_valid   = '0;
    #1;
    chk("bp_release_pre_m_valid", 32'(m_valid), 32'h1);
    tick();
    chk("bp_release_m_valid", 32'(m_valid), 32'h0);
    chk("bp_release_busy",    32'(busy),    32'h0);

    // All four requesting continuously from rr_ptr=0.
    s_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_s_ready", 32'(s_ready), 32'(1 << exp_e[k]));
      tick();
      chk("rr_m_id",         32'(m_id),    32'(exp_e[k]));
      chk("rr_m_data",       32'(m_data),  32'(16'h1000 + exp_e[k]));
      chk("rr_s_ready_send", 32'(s_ready), 32'h0);
      tick();
    end

    // Reset asserted between edges while a word is held.
    m_ready = 1'b0;
    #1;
    chk("rstmid_s_ready", 32'(s_ready), 32'(1 << exp_f));
    tick();
    chk("rstmid_m_valid_pre", 32'(m_valid), 32'h1);
    chk("rstmid_m_id_pre",    32'(m_id),    32'(exp_f));
    #3;
    rstn = 1'b0;
    #1;
    chk("rstmid_m_valid", 32'(m_valid), 32'h0);
    chk("rstmid_busy",    32'(busy),    32'h0);
    chk("rstmid_s_ready", 32'(s_ready), 32'h0);
    chk("rstmid_m_data",  32'(m_data),  32'h0);
    tick();
    rstn    = 1'b1;
    s_valid = 4'b1010;
    m_ready = 1'b1;
    #1;
    chk("post_rst_s_ready", 32'(s_ready), 32'h2);
    tick();
    chk("post_rst_m_id",   32'(m_id),   32'h1);
    chk("post_rst_m_data", 32'(m_data), 32'h1001);
    tick();

    // No requests: stay idle.
    s_valid = '0;
    #1;
    chk("none_s_ready", 32'(s_ready), 32'h0);
    tick();
    chk("none_m_valid", 32'(m_valid), 32'h0);

    // Requesters 0 and 2, then requester 0 drops.
    for (int k = 0; k < 5; k++) begin
      s_valid = (k < 3) ? 4'b0101 : 4'b0100;
      #1;
      chk("pair_s_ready", 32'(s_ready), 32'(1 << exp_g[k]));
      tick();
      chk("pair_m_id", 32'(m_id), 32'(exp_g[k]));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
